// File: rtl/aurora_lite_fifo.sv
// Aurora-side stream bridge: one FIFO per direction between the user AXI-Stream
// pair and the GT pair, with packet-safe internal loopback and saturating frame counters.

module aurora_lite_fifo_buf #(
  parameter int W     = 257,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] wr_cnt;
  logic [LW-1:0] rd_cnt;

  // Counters carry one extra bit so full and empty stay distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + LW'(1);
      if (rd_en) rd_cnt <= rd_cnt + LW'(1);
    end
  end

  // Storage is data only, never reset; consumers qualify it with level.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_cnt[AW-1:0]];
  assign level   = wr_cnt - rd_cnt;

endmodule

module aurora_lite_fifo #(
  parameter int DW    = 256,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             GT_DIFF_REFCLK1,
  input  logic             RESETN,
  input  logic             LOOPBACK,
  input  logic             CLEAR_COUNTS,
  input  logic [DW-1:0]    USER_DATA_S_AXIS_TX_TDATA,
  input  logic             USER_DATA_S_AXIS_TX_TVALID,
  input  logic             USER_DATA_S_AXIS_TX_TLAST,
  output logic             USER_DATA_S_AXIS_TX_TREADY,
  output logic [DW-1:0]    USER_DATA_M_AXIS_RX_TDATA,
  output logic             USER_DATA_M_AXIS_RX_TVALID,
  output logic             USER_DATA_M_AXIS_RX_TLAST,
  input  logic             USER_DATA_M_AXIS_RX_TREADY,
  input  logic [DW-1:0]    GT_SERIAL_RX_TDATA,
  input  logic             GT_SERIAL_RX_TVALID,
  input  logic             GT_SERIAL_RX_TLAST,
  output logic             GT_SERIAL_RX_TREADY,
  output logic [DW-1:0]    GT_SERIAL_TX_TDATA,
  output logic             GT_SERIAL_TX_TVALID,
  output logic             GT_SERIAL_TX_TLAST,
  input  logic             GT_SERIAL_TX_TREADY,
  output logic             MODE_ACTIVE,
  output logic [LW-1:0]    TX_LEVEL,
  output logic [LW-1:0]    RX_LEVEL,
  output logic [CNT_W-1:0] TX_FRAMES,
  output logic [CNT_W-1:0] RX_FRAMES
);

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_LOOP   = 1'b1
  } mode_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  mode_t         mode_q;
  mode_t         mode_d;
  logic          tx_open;
  logic          rx_open;
  logic          switch_ok;

  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic [DW:0]   tx_head;
  logic [DW:0]   rx_head;
  logic [DW:0]   tx_wr_data;
  logic [DW:0]   rx_wr_data;
  logic          tx_not_full;
  logic          rx_not_full;
  logic          tx_avail;
  logic          rx_avail;
  logic          tx_wr;
  logic          tx_rd;
  logic          rx_wr;
  logic          rx_rd;
  logic          loop_on;
  logic          gt_tx_vld;
  logic          user_rx_vld;

  assign loop_on     = (mode_q == MODE_LOOP);
  assign tx_not_full = (tx_level != LW'(DEPTH));
  assign rx_not_full = (rx_level != LW'(DEPTH));
  assign tx_avail    = (tx_level != '0);
  assign rx_avail    = (rx_level != '0);

  // TX FIFO write side: user transmit stream
  assign tx_wr_data = {USER_DATA_S_AXIS_TX_TLAST, USER_DATA_S_AXIS_TX_TDATA};
  assign tx_wr      = USER_DATA_S_AXIS_TX_TVALID & tx_not_full;

  aurora_lite_fifo_buf #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (GT_DIFF_REFCLK1),
    .rst_n   (RESETN),
    .wr_en   (tx_wr),
    .wr_data (tx_wr_data),
    .rd_en   (tx_rd),
    .rd_data (tx_head),
    .level   (tx_level)
  );

  // TX FIFO read side: GT link in normal mode, RX FIFO in loopback
  assign gt_tx_vld  = tx_avail & ~loop_on;
  assign tx_rd      = tx_avail & (loop_on ? rx_not_full : GT_SERIAL_TX_TREADY);

  // RX FIFO write side: source selected by the mode in force
  assign rx_wr_data = loop_on ? tx_head : {GT_SERIAL_RX_TLAST, GT_SERIAL_RX_TDATA};
  assign rx_wr      = loop_on ? tx_rd : (GT_SERIAL_RX_TVALID & rx_not_full);

  aurora_lite_fifo_buf #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (GT_DIFF_REFCLK1),
    .rst_n   (RESETN),
    .wr_en   (rx_wr),
    .wr_data (rx_wr_data),
    .rd_en   (rx_rd),
    .rd_data (rx_head),
    .level   (rx_level)
  );

  // RX FIFO read side: user receive stream
  assign user_rx_vld = rx_avail;
  assign rx_rd       = rx_avail & USER_DATA_M_AXIS_RX_TREADY;

  // Mode may only flip on a packet boundary at both tracked points.
  assign switch_ok = ~tx_open & ~rx_open
                   & ~(tx_rd & ~tx_head[DW])
                   & ~(rx_wr & ~rx_wr_data[DW]);

  always_comb begin
    mode_d = mode_q;
    if (switch_ok) mode_d = LOOPBACK ? MODE_LOOP : MODE_NORMAL;
  end

  always_ff @(posedge GT_DIFF_REFCLK1 or negedge RESETN) begin
    if (!RESETN) begin
      mode_q  <= MODE_NORMAL;
      tx_open <= 1'b0;
      rx_open <= 1'b0;
    end else begin
      mode_q <= mode_d;
      if (tx_rd) tx_open <= ~tx_head[DW];
      if (rx_wr) rx_open <= ~rx_wr_data[DW];
    end
  end

  always_ff @(posedge GT_DIFF_REFCLK1 or negedge RESETN) begin
    if (!RESETN) begin
      TX_FRAMES <= '0;
      RX_FRAMES <= '0;
    end else if (CLEAR_COUNTS) begin
      TX_FRAMES <= '0;
      RX_FRAMES <= '0;
    end else begin
      if (gt_tx_vld & GT_SERIAL_TX_TREADY & tx_head[DW]) TX_FRAMES <= sat_inc(TX_FRAMES);
      if (rx_rd & rx_head[DW])                           RX_FRAMES <= sat_inc(RX_FRAMES);
    end
  end

  // Data outputs are zeroed whenever not valid so reset shows clean zeros.
  assign GT_SERIAL_TX_TVALID        = gt_tx_vld;
  assign GT_SERIAL_TX_TDATA         = gt_tx_vld ? tx_head[DW-1:0] : '0;
  assign GT_SERIAL_TX_TLAST         = gt_tx_vld & tx_head[DW];
  assign USER_DATA_M_AXIS_RX_TVALID = user_rx_vld;
  assign USER_DATA_M_AXIS_RX_TDATA  = user_rx_vld ? rx_head[DW-1:0] : '0;
  assign USER_DATA_M_AXIS_RX_TLAST  = user_rx_vld & rx_head[DW];
  assign USER_DATA_S_AXIS_TX_TREADY = tx_not_full;
  assign GT_SERIAL_RX_TREADY        = loop_on | rx_not_full;
  assign MODE_ACTIVE                = loop_on;
  assign TX_LEVEL                   = tx_level;
  assign RX_LEVEL                   = rx_level;

endmodule

// File: tb/tb_aurora_lite_fifo.sv
// Directed bench for aurora_lite_fifo: queue-level reference model checked every
// cycle on the falling edge, plus literal expectations for each scenario.

module tb_aurora_lite_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             RESETN;
  logic             LOOPBACK;
  logic             CLEAR_COUNTS;
  logic [DW-1:0]    S_TDATA;
  logic             S_TVALID, S_TLAST, S_TREADY;
  logic [DW-1:0]    M_TDATA;
  logic             M_TVALID, M_TLAST, M_TREADY;
  logic [DW-1:0]    GR_TDATA;
  logic             GR_TVALID, GR_TLAST, GR_TREADY;
  logic [DW-1:0]    GT_TDATA;
  logic             GT_TVALID, GT_TLAST, GT_TREADY;
  logic             MODE_ACTIVE;
  logic [LW-1:0]    TX_LEVEL, RX_LEVEL;
  logic [CNT_W-1:0] TX_FRAMES, RX_FRAMES;

  always #5 clk = ~clk;

  aurora_lite_fifo #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .GT_DIFF_REFCLK1            (clk),
    .RESETN                     (RESETN),
    .LOOPBACK                   (LOOPBACK),
    .CLEAR_COUNTS               (CLEAR_COUNTS),
    .USER_DATA_S_AXIS_TX_TDATA  (S_TDATA),
    .USER_DATA_S_AXIS_TX_TVALID (S_TVALID),
    .USER_DATA_S_AXIS_TX_TLAST  (S_TLAST),
    .USER_DATA_S_AXIS_TX_TREADY (S_TREADY),
    .USER_DATA_M_AXIS_RX_TDATA  (M_TDATA),
    .USER_DATA_M_AXIS_RX_TVALID (M_TVALID),
    .USER_DATA_M_AXIS_RX_TLAST  (M_TLAST),
    .USER_DATA_M_AXIS_RX_TREADY (M_TREADY),
    .GT_SERIAL_RX_TDATA         (GR_TDATA),
    .GT_SERIAL_RX_TVALID        (GR_TVALID),
    .GT_SERIAL_RX_TLAST         (GR_TLAST),
    .GT_SERIAL_RX_TREADY        (GR_TREADY),
    .GT_SERIAL_TX_TDATA         (GT_TDATA),
    .GT_SERIAL_TX_TVALID        (GT_TVALID),
    .GT_SERIAL_TX_TLAST         (GT_TLAST),
    .GT_SERIAL_TX_TREADY        (GT_TREADY),
    .MODE_ACTIVE                (MODE_ACTIVE),
    .TX_LEVEL                   (TX_LEVEL),
    .RX_LEVEL                   (RX_LEVEL),
    .TX_FRAMES                  (TX_FRAMES),
    .RX_FRAMES                  (RX_FRAMES)
  );

  int checks = 0;
  int errors = 0;
  int gt_out_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: two queues of {last,data}, mode flag, open flags, counters.
  logic [DW:0] m_tx[$];
  logic [DW:0] m_rx[$];
  bit m_mode = 0, m_tx_open = 0, m_rx_open = 0;
  int m_txf = 0, m_rxf = 0;

  always @(negedge clk) begin
    if (!RESETN) begin
      m_tx.delete(); m_rx.delete();
      m_mode = 0; m_tx_open = 0; m_rx_open = 0; m_txf = 0; m_rxf = 0;
      chk("rst_gt_tx_tvalid", GT_TVALID, 0);
      chk("rst_gt_tx_tdata", {GT_TLAST, GT_TDATA}, 0);
      chk("rst_user_rx_tvalid", M_TVALID, 0);
      chk("rst_user_rx_tdata", {M_TLAST, M_TDATA}, 0);
      chk("rst_levels", {TX_LEVEL, RX_LEVEL}, 0);
      chk("rst_treadys", {S_TREADY, GR_TREADY}, 2'b11);
      chk("rst_mode_frames", {MODE_ACTIVE, TX_FRAMES, RX_FRAMES}, 0);
    end else begin
      bit tx_full, rx_full, tx_in, tx_out, rx_in, rx_out, ok;
      logic [DW:0] tx_beat, rx_beat_in, rx_beat_out;
      tx_full = (m_tx.size() == DEPTH);
      rx_full = (m_rx.size() == DEPTH);

      chk("user_tx_tready", S_TREADY, !tx_full);
      chk("gt_tx_tvalid", GT_TVALID, !m_mode && m_tx.size() > 0);
      if (!m_mode && m_tx.size() > 0) chk("gt_tx_beat", {GT_TLAST, GT_TDATA}, m_tx[0]);
      chk("user_rx_tvalid", M_TVALID, m_rx.size() > 0);
      if (m_rx.size() > 0) chk("user_rx_beat", {M_TLAST, M_TDATA}, m_rx[0]);
      chk("gt_rx_tready", GR_TREADY, m_mode || !rx_full);
      chk("tx_level", TX_LEVEL, m_tx.size());
      chk("rx_level", RX_LEVEL, m_rx.size());
      chk("mode_active", MODE_ACTIVE, m_mode);
      chk("tx_frames", TX_FRAMES, m_txf);
      chk("rx_frames", RX_FRAMES, m_rxf);

      if (GT_TVALID && GT_TREADY) gt_out_cnt++;

      tx_in  = S_TVALID && !tx_full;
      tx_out = m_tx.size() > 0 && (m_mode ? !rx_full : GT_TREADY);
      rx_out = m_rx.size() > 0 && M_TREADY;
      rx_in  = m_mode ? tx_out : (GR_TVALID && !rx_full);
      tx_beat     = tx_out ? m_tx[0] : '0;
      rx_beat_out = rx_out ? m_rx[0] : '0;
      rx_beat_in  = m_mode ? tx_beat : {GR_TLAST, GR_TDATA};

      ok = !m_tx_open && !m_rx_open && !(tx_out && !tx_beat[DW]) && !(rx_in && !rx_beat_in[DW]);

      if (tx_out) begin
        void'(m_tx.pop_front());
        if (!m_mode && tx_beat[DW] && m_txf < MAXC) m_txf++;
        m_tx_open = !tx_beat[DW];
      end
      if (rx_out) begin
        void'(m_rx.pop_front());
        if (rx_beat_out[DW] && m_rxf < MAXC) m_rxf++;
      end
      if (rx_in) begin
        m_rx.push_back(rx_beat_in);
        m_rx_open = !rx_beat_in[DW];
      end
      if (tx_in) m_tx.push_back({S_TLAST, S_TDATA});
      if (CLEAR_COUNTS) begin m_txf = 0; m_rxf = 0; end
      if (ok) m_mode = LOOPBACK;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int base, acc;
    RESETN = 0; LOOPBACK = 0; CLEAR_COUNTS = 0;
    S_TDATA = '0; S_TVALID = 0; S_TLAST = 0; M_TREADY = 1;
    GR_TDATA = '0; GR_TVALID = 0; GR_TLAST = 0; GT_TREADY = 1;
    repeat (3) step();
    chk("lit_rst_user_tready", S_TREADY, 1);
    RESETN = 1;
    step();

    // Normal streaming: 4 packets of 10 beats
    base = gt_out_cnt;
    for (int i = 0; i < 40; i++) begin
      S_TDATA = 32'h1000 + i; S_TLAST = (i % 10 == 9); S_TVALID = 1;
      step();
      if (i == 0) begin
        chk("lit_first_out_valid", GT_TVALID, 1);
        chk("lit_first_out_data", GT_TDATA, 32'h1000);
      end
    end
    S_TVALID = 0; S_TLAST = 0;
    repeat (4) step();
    chk("lit_stream_frames", TX_FRAMES, 4);
    chk("lit_stream_beats", gt_out_cnt - base, 40);

    // Backpressure until full, then release
    GT_TREADY = 0; acc = 0; base = gt_out_cnt;
    for (int c = 0; c < 30; c++) begin
      S_TDATA = 32'h2000 + acc; S_TLAST = (acc % 4 == 3); S_TVALID = 1;
      if (S_TREADY) acc++;
      step();
    end
    chk("lit_full_level", TX_LEVEL, 16);
    chk("lit_full_tready", S_TREADY, 0);
    chk("lit_full_accepts", acc, 16);
    S_TVALID = 0; S_TLAST = 0; GT_TREADY = 1;
    repeat (20) step();
    chk("lit_release_beats", gt_out_cnt - base, 16);
    chk("lit_release_frames", TX_FRAMES, 8);

    // Loopback: switch while idle, 3 packets of 4, GT RX junk discarded
    LOOPBACK = 1;
    step();
    chk("lit_lb_mode", MODE_ACTIVE, 1);
    base = gt_out_cnt;
    GR_TDATA = 32'hDEAD; GR_TLAST = 1; GR_TVALID = 1;
    for (int i = 0; i < 12; i++) begin
      S_TDATA = 32'h3000 + i; S_TLAST = (i % 4 == 3); S_TVALID = 1;
      step();
      if (i == 0) chk("lit_lb_rx_not_yet", M_TVALID, 0);
      if (i == 1) begin
        chk("lit_lb_rx_valid", M_TVALID, 1);
        chk("lit_lb_rx_data", M_TDATA, 32'h3000);
      end
      chk("lit_lb_gt_rx_tready", GR_TREADY, 1);
    end
    S_TVALID = 0; S_TLAST = 0;
    repeat (6) step();
    GR_TVALID = 0; GR_TLAST = 0;
    chk("lit_lb_rx_frames", RX_FRAMES, 3);
    chk("lit_lb_no_gt_tx", gt_out_cnt - base, 0);
    step();
    LOOPBACK = 0;
    repeat (3) step();
    chk("lit_lb_exit", MODE_ACTIVE, 0);

    // Loopback requested in the middle of an 8-beat packet
    base = gt_out_cnt;
    for (int i = 0; i < 8; i++) begin
      S_TDATA = 32'h4000 + i; S_TLAST = (i == 7); S_TVALID = 1;
      if (i == 3) LOOPBACK = 1;
      step();
      chk("lit_mid_mode_held", MODE_ACTIVE, 0);
    end
    S_TVALID = 0; S_TLAST = 0;
    step();
    chk("lit_mid_mode_at_tlast", MODE_ACTIVE, 0);
    step();
    chk("lit_mid_mode_after", MODE_ACTIVE, 1);
    chk("lit_mid_beats_on_gt", gt_out_cnt - base, 8);
    LOOPBACK = 0;
    repeat (3) step();

    // Counter saturation then clear coinciding with a TLAST handshake
    for (int i = 0; i < 20; i++) begin
      S_TDATA = 32'h5000 + i; S_TLAST = 1; S_TVALID = 1;
      step();
    end
    S_TVALID = 0; S_TLAST = 0;
    repeat (3) step();
    chk("lit_sat_tx_frames", TX_FRAMES, 15);
    S_TDATA = 32'h5555; S_TLAST = 1; S_TVALID = 1;
    step();
    S_TVALID = 0; S_TLAST = 0; CLEAR_COUNTS = 1;
    step();
    CLEAR_COUNTS = 0;
    chk("lit_clear_tx_frames", TX_FRAMES, 0);
    chk("lit_clear_rx_frames", RX_FRAMES, 0);
    repeat (2) step();

    // Async reset with both FIFOs half full
    GT_TREADY = 0; M_TREADY = 0;
    for (int i = 0; i < 8; i++) begin
      S_TDATA = 32'h6000 + i; S_TLAST = 0; S_TVALID = 1;
      GR_TDATA = 32'h7000 + i; GR_TLAST = 0; GR_TVALID = 1;
      step();
    end
    S_TVALID = 0; GR_TVALID = 0;
    chk("lit_half_tx_level", TX_LEVEL, 8);
    chk("lit_half_rx_level", RX_LEVEL, 8);
    #1 RESETN = 0;
    #1;
    chk("lit_arst_levels", {TX_LEVEL, RX_LEVEL}, 0);
    chk("lit_arst_valids", {GT_TVALID, M_TVALID}, 0);
    chk("lit_arst_data", {GT_TLAST, GT_TDATA, M_TLAST, M_TDATA}, 0);
    chk("lit_arst_treadys", {S_TREADY, GR_TREADY}, 2'b11);
    repeat (2) step();
    RESETN = 1; GT_TREADY = 1; M_TREADY = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      S_TDATA = 32'h8000 + i; S_TLAST = (i == 2); S_TVALID = 1;
      step();
    end
    S_TVALID = 0; S_TLAST = 0;
    repeat (5) step();
    chk("lit_post_rst_frames", TX_FRAMES, 1);
    chk("lit_post_rst_level", TX_LEVEL, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
